param_rom_ram_unit: RTL and testbench

- Parametrised successor to the lab4 fixed 16x5 ROM.
- Holds a read-only lookup table (ROM) and a same-sized writable RAM, accessed through a single valid/ready command port.
- Supports four operations: read, write, read-modify-write XOR with the ROM word, and a multi-cycle bulk copy of the whole ROM into RAM.
- Intended as the memory stage the lab datapath/FSM exercises drive.

---
 rtl/mem_unit_pkg.sv | 16 +
 rtl/rom_lut.sv | 17 +
 rtl/param_rom_ram_unit.sv | 150 +++++++++++++++
 tb/tb_param_rom_ram_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_unit_pkg.sv
// Shared encodings for param_rom_ram_unit.
//   MODE_*  : op_mode command encodings on the command port.
//   state_e : control FSM state (ST_IDLE accepts commands, ST_COPY runs the bulk copy).
package mem_unit_pkg;

    localparam logic [1:0] MODE_READ      = 2'b00;
    localparam logic [1:0] MODE_WRITE     = 2'b01;
    localparam logic [1:0] MODE_XOR_ROM   = 2'b10;
    localparam logic [1:0] MODE_BULK_COPY = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_COPY
    } state_e;

endpackage

// File: rtl/rom_lut.sv
// Combinational constant lookup table: rom_o = (3 * addr_i) mod 2**DATA_W.
// Ports:
//   addr_i  word address
//   rom_o   table word at addr_i
module rom_lut #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] rom_o
);

    // 3*a = a + 2*a; each term is reduced to DATA_W bits first, which keeps the
    // result correct modulo 2**DATA_W for any ADDR_W/DATA_W ratio.
    assign rom_o = DATA_W'(addr_i) + DATA_W'({addr_i, 1'b0});

endmodule

// File: rtl/param_rom_ram_unit.sv
// ROM + same-sized RAM behind one valid/ready command port.
// Operations: READ, WRITE, XOR_ROM (ram ^= rom, result returned) and BULK_COPY
// (copies the whole ROM into RAM over DEPTH cycles, ascending addresses).
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears RAM too)
//   op_valid/op_ready    command handshake; ready only while idle
//   op_mode, addr, din   command, word address, write data
//   dout, dout_valid     registered result word and its one-cycle pulse
//   busy, copy_done      bulk copy in progress / one-cycle completion pulse
module param_rom_ram_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              copy_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                busy_q, busy_d;
    logic                copy_done_q, copy_done_d;
    logic [DATA_W-1:0]   ram_q [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rom_at_addr;
    logic [DATA_W-1:0]   rom_at_cnt;

    rom_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom_addr (
        .addr_i (addr),
        .rom_o  (rom_at_addr)
    );

    rom_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom_cnt (
        .addr_i (cnt_q),
        .rom_o  (rom_at_cnt)
    );

    assign op_ready   = (state_q == ST_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign copy_done  = copy_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;
        copy_done_d  = 1'b0;
        we           = 1'b0;
        waddr        = addr;
        wdata        = din;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    unique case (op_mode)
                        MODE_READ: begin
                            dout_d       = ram_q[addr];
                            dout_valid_d = 1'b1;
                        end
                        MODE_WRITE: begin
                            we = 1'b1;
                        end
                        MODE_XOR_ROM: begin
                            we           = 1'b1;
                            wdata        = ram_q[addr] ^ rom_at_addr;
                            dout_d       = wdata;
                            dout_valid_d = 1'b1;
                        end
                        MODE_BULK_COPY: begin
                            state_d = ST_COPY;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_COPY: begin
                we           = 1'b1;
                waddr        = cnt_q;
                wdata        = rom_at_cnt;
                dout_valid_d = dout_valid_q;
                // Counter wraps back to 0 on the last word, so no overflow bit.
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    copy_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            copy_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            copy_done_q  <= copy_done_d;
        end
    end

    // RAM is flop-based so that reset can clear every word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (we) begin
            ram_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_param_rom_ram_unit.sv
module tb_param_rom_ram_unit;
    import mem_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Default-parameter instance (16 x 5).
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_mode  = MODE_READ;
    logic [3:0] addr     = '0;
    logic [4:0] din      = '0;
    logic [4:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       copy_done;

    // Small instance (8 x 8).
    logic       s_op_valid = 1'b0;
    logic       s_op_ready;
    logic [1:0] s_op_mode  = MODE_READ;
    logic [2:0] s_addr     = '0;
    logic [7:0] s_din      = '0;
    logic [7:0] s_dout;
    logic       s_dout_valid;
    logic       s_busy;
    logic       s_copy_done;

    int n_checks = 0;
    int n_errors = 0;

    int mdl_ram [16];
    int exp_dout;

    always #5 clk = ~clk;

    param_rom_ram_unit #(.ADDR_W(4), .DATA_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_mode    (op_mode),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .copy_done  (copy_done)
    );

    param_rom_ram_unit #(.ADDR_W(3), .DATA_W(8)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (s_op_valid),
        .op_ready   (s_op_ready),
        .op_mode    (s_op_mode),
        .addr       (s_addr),
        .din        (s_din),
        .dout       (s_dout),
        .dout_valid (s_dout_valid),
        .busy       (s_busy),
        .copy_done  (s_copy_done)
    );

    function automatic int rom_val(input int i, input int dw);
        return (3 * i) % (1 << dw);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accepted single-word op on the main instance; checks the cycle after.
    task automatic do_op(input logic [1:0] m, input int a, input int d);
        @(negedge clk);
        op_valid = 1'b1;
        op_mode  = m;
        addr     = 4'(a);
        din      = 5'(d);
        check("ready_before_op", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        case (m)
            MODE_READ: begin
                exp_dout = mdl_ram[a];
                check("rd_dv", 32'(dout_valid), 32'd1);
            end
            MODE_WRITE: begin
                mdl_ram[a] = d % 32;
                check("wr_dv", 32'(dout_valid), 32'd0);
            end
            default: begin
                mdl_ram[a] = mdl_ram[a] ^ rom_val(a, 5);
                exp_dout   = mdl_ram[a];
                check("xor_dv", 32'(dout_valid), 32'd1);
            end
        endcase
        check("dout", 32'(dout), 32'(exp_dout));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_dv", 32'(dout_valid), 32'd0);
    endtask

    // Bulk copy on the main instance while a WRITE to addr 0 is held on the port.
    task automatic bulk_copy_main();
        int busy_cycles;
        int done_pulses;
        int bad_ready;
        int bad_done;
        busy_cycles = 0;
        done_pulses = 0;
        bad_ready   = 0;
        bad_done    = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_mode  = MODE_BULK_COPY;
        @(posedge clk);
        #1;
        op_mode = MODE_WRITE;
        addr    = 4'd0;
        din     = 5'h1F;
        for (int k = 0; k < 24; k++) begin
            if (busy) busy_cycles++;
            if (op_ready == busy) bad_ready++;
            if (copy_done) begin
                done_pulses++;
                if (busy) bad_done++;
            end
            // Drop the ignored write as soon as the unit would accept it.
            op_valid = busy;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        check("copy_busy_cycles", 32'(busy_cycles), 32'd16);
        check("copy_done_pulses", 32'(done_pulses), 32'd1);
        check("copy_ready_vs_busy", 32'(bad_ready), 32'd0);
        check("copy_done_after_busy", 32'(bad_done), 32'd0);
        for (int i = 0; i < 16; i++) mdl_ram[i] = rom_val(i, 5);
    endtask

    task automatic small_op(input logic [1:0] m, input int a);
        @(negedge clk);
        s_op_valid = 1'b1;
        s_op_mode  = m;
        s_addr     = 3'(a);
        @(posedge clk);
        #1;
        s_op_valid = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        int m;
        int a;
        int d;

        for (int i = 0; i < 16; i++) mdl_ram[i] = 0;
        exp_dout = 0;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(copy_done), 32'd0);
        check("rst_ready", 32'(op_ready), 32'd1);

        // Fresh RAM reads back zeros, back-to-back.
        for (int i = 0; i < 16; i++) do_op(MODE_READ, i, 0);
        idle_cycle();

        // Write then immediate read.
        do_op(MODE_WRITE, 3, 'h15);
        do_op(MODE_READ, 3, 0);
        idle_cycle();

        bulk_copy_main();
        do_op(MODE_READ, 0, 0);
        do_op(MODE_READ, 2, 0);
        check("copy_rd2", 32'(dout), 32'h06);
        do_op(MODE_READ, 15, 0);
        check("copy_rd15", 32'(dout), 32'h0D);
        do_op(MODE_READ, 3, 0);

        // Write then XOR with ROM.
        do_op(MODE_WRITE, 2, 'h1F);
        do_op(MODE_XOR_ROM, 2, 0);
        check("xor2", 32'(dout), 32'h19);
        do_op(MODE_READ, 2, 0);
        check("xor2_rd", 32'(dout), 32'h19);
        idle_cycle();

        // Random single-word traffic against the model.
        for (int n = 0; n < 200; n++) begin
            m = int'($urandom_range(0, 2));
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 31));
            do_op(2'(m), a, d);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset during the 5th copy cycle.
        @(negedge clk);
        op_valid = 1'b1;
        op_mode  = MODE_BULK_COPY;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(copy_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl_ram[i] = 0;
        exp_dout = 0;
        #1;
        check("midrst_ready", 32'(op_ready), 32'd1);
        check("midrst_dout", 32'(dout), 32'd0);
        for (int i = 0; i < 5; i++) do_op(MODE_READ, i, 0);
        idle_cycle();

        // Narrow-address, wide-data instance.
        small_op(MODE_BULK_COPY, 0);
        busy_cycles = 0;
        done_pulses = 0;
        for (int k = 0; k < 16; k++) begin
            if (s_busy) busy_cycles++;
            if (s_copy_done) done_pulses++;
            @(posedge clk);
            #1;
        end
        check("small_busy_cycles", 32'(busy_cycles), 32'd8);
        check("small_done_pulses", 32'(done_pulses), 32'd1);
        small_op(MODE_READ, 7);
        check("small_rd7_dv", 32'(s_dout_valid), 32'd1);
        check("small_rd7", 32'(s_dout), 32'd21);
        small_op(MODE_READ, 5);
        check("small_rd5", 32'(s_dout), 32'(rom_val(5, 8)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
